// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the elastic pipeline stage register.
// The stage state is encoded so that its value equals the number of held entries.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // RISC-V NOP: addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter.
// Once it reaches all-ones it holds there until reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, flush and a stall counter.
// All outputs are decoded from registers only.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | nothing held; bubble on data_o; accepting
// ST_BUSY  | main holds the head; accepting
// ST_FULL  | main and skid both held; not accepting
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(RV_NOP),
    parameter int                CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              fire_in;
    logic              fire_out;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        fire_in  = valid_i & ready_o & ~flush_i;
        fire_out = valid_o & ready_i;

        case (state_q)
            ST_EMPTY: begin
                if (fire_in) begin
                    main_d  = data_i;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (fire_in && fire_out) begin
                    main_d = data_i;
                end else if (fire_in) begin
                    skid_d  = data_i;
                    state_d = ST_FULL;
                end else if (fire_out) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (fire_out) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // A head consumed during flush is still delivered; everything else is squashed.
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
    end

    assign valid_o     = (state_q != ST_EMPTY);
    assign ready_o     = (state_q != ST_FULL);
    assign occupancy_o = state_q;
    assign data_o      = valid_o ? main_q : BUBBLE;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (valid_o & ~ready_i),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a FIFO model of accepted payloads is
// compared against the stage outputs on every falling edge.
module tb_pipe_stage_reg;

    localparam int          DATA_W = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              valid_in = 1'b0;
    logic              ready_out;
    logic [DATA_W-1:0] data_in = '0;
    logic              valid_out;
    logic              ready_in = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                stall_m = 0;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .BUBBLE (NOP),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .valid_i     (valid_in),
        .ready_o     (ready_out),
        .data_i      (data_in),
        .valid_o     (valid_out),
        .ready_i     (ready_in),
        .data_o      (data_out),
        .occupancy_o (occupancy),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model of the stage: a bounded FIFO plus a saturating stall count.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_m = 0;
        end else begin
            int  sz;
            logic [DATA_W-1:0] head;
            sz = exp_q.size();
            head = (sz != 0) ? exp_q[0] : NOP;
            check("occupancy", 32'(occupancy), 32'(sz));
            check("valid_o", 32'(valid_out), 32'(sz != 0));
            check("ready_o", 32'(ready_out), 32'(sz < 2));
            check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
            check("data_o", data_out, head);
            if (sz != 0 && ready_in) void'(exp_q.pop_front());
            if (sz != 0 && !ready_in && stall_m != (2**CNT_W - 1)) stall_m++;
            if (flush) exp_q.delete();
            else if (valid_in && sz < 2) exp_q.push_back(data_in);
        end
    end

    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        ready_in = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_data", data_out, NOP);
        check("rst_stall", 32'(stall_cnt), 32'd0);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("stream_stall", 32'(stall_cnt), 32'd0);

        // Backpressure fills the skid, then drains in order
        do_reset();
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        check("bp_ready", 32'(ready_out), 32'd0);
        check("bp_occ", 32'(occupancy), 32'd2);
        cycle(1'b1, 32'h33, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b1, 1'b0);
        cycle(1'b1, 32'h33, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("bp_stall", 32'(stall_cnt), 32'd2);
        check("bp_empty", 32'(valid_out), 32'd0);

        // Flush while full drops held entries and the offered input
        do_reset();
        cycle(1'b1, 32'h71, 1'b0, 1'b0);
        cycle(1'b1, 32'h72, 1'b0, 1'b0);
        cycle(1'b1, 32'h44, 1'b0, 1'b1);
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_valid", 32'(valid_out), 32'd0);
        check("flush_data", data_out, NOP);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush and drain in the same cycle
        do_reset();
        cycle(1'b1, 32'h55, 1'b0, 1'b0);
        check("fd_head", data_out, 32'h55);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("fd_occ", 32'(occupancy), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Stall counter saturation
        do_reset();
        cycle(1'b1, 32'h66, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("sat_stall", 32'(stall_cnt), 32'hF);

        // Asynchronous reset mid-cycle with two entries held
        do_reset();
        cycle(1'b1, 32'hB1, 1'b0, 1'b0);
        cycle(1'b1, 32'hB2, 1'b0, 1'b0);
        valid_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(valid_out), 32'd0);
        check("arst_ready", 32'(ready_out), 32'd1);
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_data", data_out, NOP);
        check("arst_stall", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
